fpu_cvt_to_float_pipe: RTL and testbench
========================================

Name: fpu_cvt_to_float_pipe

Overview:
Pipelined integer-to-single-precision converter for FCVT.S.W/WU and, with IN_WIDTH=64, FCVT.S.L/LU. It sits in the FPU arithmetic path behind the issue logic. It has three register stages with valid/ready handshaking per stage, bubble collapsing, flush, tag passthrough and IEEE inexact-flag reporting. All RISC-V static rounding modes are supported.

Parameters:
IN_WIDTH, 32, integer operand width; legal values are 32 and 64 only.
TAG_WIDTH, 5, width of the opaque tag (destination register) carried alongside each operand.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
reset_i  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous kill of all in-flight operations
in_valid_i  input  1  operand valid
in_ready_o  output  1  converter can accept an operand this cycle
a_i  input  IN_WIDTH  integer operand
is_unsigned_i  input  1  1 = treat a_i as unsigned, 0 = two's complement
rm_i  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
tag_i  input  TAG_WIDTH  opaque tag
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts the result
result_o  output  32  IEEE-754 binary32 result
fflags_o  output  5  {NV,DZ,OF,UF,NX}
tag_o  output  TAG_WIDTH  tag of the result

Behaviour:
- Reset (reset_i=0, asynchronous): all stage valid bits clear. out_valid_o=0, in_ready_o=1 after release. result_o=0, fflags_o=0, tag_o=0.
- Handshake:
  - A transfer occurs when valid and ready are both 1.
  - Per-stage advance: adv3 = ~v3 | out_ready_i; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2; in_ready_o = adv1.
  - Bubbles collapse.
  - Throughput is 1 per cycle with no back-pressure.
  - Latency is exactly 3 cycles from input accept to out_valid_o.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- S1 (sign/magnitude):
  - sign = ~is_unsigned_i & a_i[MSB].
  - mag = sign ? -a_i : a_i, computed at IN_WIDTH bits, so the most negative value maps to 2^(IN_WIDTH-1).
  - lzc = leading-zero count of mag.
  - Register sign, mag, lzc, rm, tag, and zero = (mag==0).
- S2 (normalise):
  - norm = mag << lzc, so the MSB of norm is set unless zero.
  - msb_pos = IN_WIDTH-1-lzc.
  - From norm take the 24-bit significand (hidden bit included), guard bit G, and sticky S = OR of all remaining lower bits.
  - Register these.
- S3 (round/pack):
  - LSB = significand bit 0.
  - Round increment by mode:
    - RNE: G&(S|LSB)
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: ~sign&(G|S)
    - RMM: G
  - rm values 101/110/111 are treated as RNE; decoding of dynamic rounding is done upstream.
  - sum = significand + inc, 25 bits wide.
  - On carry (sum[24]): exp = msb_pos+128 and frac = sum[23:1]. Otherwise exp = msb_pos+127 and frac = sum[22:0].
  - NX = G|S. NV, DZ, OF and UF are always 0, because |int| < 2^64 cannot overflow binary32.
  - zero: result = 32'h0000_0000 (always +0, any rm), NX=0.
- Values with msb_pos < 24 are exact: G=S=0 and NX=0.
- flush_i=1: v1, v2 and v3 clear on the next edge. An input offered in the same cycle is dropped, and in_ready_o still reflects the pre-flush state. Flush has priority over advance.
- Reset asserted mid-operation: in-flight results are discarded immediately and no partial output appears.
- Data registers are enabled only on stage advance with valid. Data registers do not need reset; only the output registers and the valid bits are reset.

Decomposition:
- Shared package fpu_cvt_pkg holds:
  - the rounding-mode constants RM_RNE..RM_RMM;
  - the fflags bit indices;
  - the binary32 constants BIAS=127 and MANT_W=23.
- One sub-module: fpu_lzc, a parametrised leading-zero counter (WIDTH in {32,64}, output clog2(WIDTH) bits, all-zero input returns WIDTH-1, with a separate zero output). It is instantiated once in S1.

Test Plan:
- IN_WIDTH=32, a_i=32'h0000_0001, signed, RNE -> result_o=32'h3F80_0000, NX=0, out_valid_o exactly 3 cycles after accept.
- a_i=32'hFFFF_FFFF: signed, RNE -> 32'hBF80_0000, NX=0. Unsigned, RNE -> 32'h4F80_0000, NX=1. Unsigned, RTZ -> 32'h4F7F_FFFF, NX=1.
- a_i=32'h8000_0000 signed -> 32'hCF00_0000, NX=0. a_i=0 with rm=RDN -> 32'h0000_0000, NX=0.
- a_i=32'h0100_0001 unsigned gives the results below (rounding tie, LSB even):

  | rm | result_o | NX |
  |---|---|---|
  | RNE | 32'h4B80_0000 | 1 |
  | RUP | 32'h4B80_0001 | 1 |
  | RMM | 32'h4B80_0001 | 1 |

- Back-pressure: stream 6 operands with tags 0..5 while out_ready_i is held 0 for 4 cycles. Required response: in_ready_o=0 once 3 operands are held, no loss or duplication, and tags emerge in order 0..5 with stable outputs while stalled.
- IN_WIDTH=64, a_i=64'h8000_0000_0000_0000 signed -> 32'hDF00_0000. Separately, assert flush_i with 3 operands in flight -> out_valid_o=0 on the next cycle. Separately, assert reset_i low mid-stream -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/fpu_cvt_pkg.sv
// Shared constants for the integer-to-binary32 converter: rounding modes,
// fflags bit positions and binary32 format parameters.
`default_nettype none

package fpu_cvt_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int BIAS   = 127;
  localparam int MANT_W = 23;

endpackage

`default_nettype wire

// File: rtl/fpu_lzc.sv
// Leading-zero counter. An all-zero input reports WIDTH-1 and raises zero_o.
`default_nettype none

module fpu_lzc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     zero_o
);

  localparam int CW = $clog2(WIDTH);

  logic found;

  always_comb begin
    cnt_o = CW'(WIDTH - 1);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        cnt_o = CW'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

  assign zero_o = ~|in_i;

endmodule

`default_nettype wire

// File: rtl/fpu_cvt_to_float_pipe.sv
// Three-stage integer to binary32 converter (sign/magnitude, normalise,
// round/pack) with per-stage valid/ready, flush and tag passthrough.
`default_nettype none

module fpu_cvt_to_float_pipe
  import fpu_cvt_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_WIDTH-1:0]  a_i,
  input  logic                 is_unsigned_i,
  input  logic [2:0]           rm_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          result_o,
  output logic [4:0]           fflags_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  localparam int LZW = $clog2(IN_WIDTH);
  localparam int SW  = MANT_W + 1;

  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3       = ~v3_q | out_ready_i;
  assign adv2       = ~v2_q | adv3;
  assign adv1       = ~v1_q | adv2;
  assign in_ready_o = adv1;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid_i;
      if (adv2) v2_q <= v1_q;
      if (adv3) v3_q <= v2_q;
    end
  end

  // S1: sign/magnitude and leading-zero count
  logic                 sign1_d, zero1_d;
  logic [IN_WIDTH-1:0]  mag1_d;
  logic [LZW-1:0]       lzc1_d;
  logic                 sign1_q, zero1_q;
  logic [IN_WIDTH-1:0]  mag1_q;
  logic [LZW-1:0]       lzc1_q;
  logic [2:0]           rm1_q;
  logic [TAG_WIDTH-1:0] tag1_q;

  assign sign1_d = ~is_unsigned_i & a_i[IN_WIDTH-1];
  assign mag1_d  = sign1_d ? (~a_i + IN_WIDTH'(1)) : a_i;

  fpu_lzc #(.WIDTH(IN_WIDTH)) u_lzc (
    .in_i   (mag1_d),
    .cnt_o  (lzc1_d),
    .zero_o (zero1_d)
  );

  always_ff @(posedge clk_i) begin
    if (adv1 && in_valid_i) begin
      sign1_q <= sign1_d;
      mag1_q  <= mag1_d;
      lzc1_q  <= lzc1_d;
      zero1_q <= zero1_d;
      rm1_q   <= rm_i;
      tag1_q  <= tag_i;
    end
  end

  // S2: normalise, extract significand, guard and sticky
  logic [IN_WIDTH-1:0]  norm;
  logic [SW-1:0]        sig2_d, sig2_q;
  logic                 g2_d, st2_d, g2_q, st2_q;
  logic [LZW-1:0]       msb2_d, msb2_q;
  logic                 sign2_q, zero2_q;
  logic [2:0]           rm2_q;
  logic [TAG_WIDTH-1:0] tag2_q;

  assign norm   = mag1_q << lzc1_q;
  assign sig2_d = norm[IN_WIDTH-1 -: SW];
  assign g2_d   = norm[IN_WIDTH-SW-1];
  assign st2_d  = |norm[IN_WIDTH-SW-2:0];
  assign msb2_d = LZW'(IN_WIDTH - 1) - lzc1_q;

  always_ff @(posedge clk_i) begin
    if (adv2 && v1_q) begin
      sig2_q  <= sig2_d;
      g2_q    <= g2_d;
      st2_q   <= st2_d;
      msb2_q  <= msb2_d;
      sign2_q <= sign1_q;
      zero2_q <= zero1_q;
      rm2_q   <= rm1_q;
      tag2_q  <= tag1_q;
    end
  end

  // S3: round and pack; a carry out of the significand bumps the exponent
  logic              inc;
  logic [SW:0]       sum;
  logic [7:0]        exp3;
  logic [MANT_W-1:0] frac3;
  logic [31:0]       res3_d, res_q;
  logic [4:0]        flags3_d, flags_q;
  logic [TAG_WIDTH-1:0] tag3_q;

  always_comb begin
    inc = 1'b0;
    case (rm2_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign2_q & (g2_q | st2_q);
      RM_RUP:  inc = ~sign2_q & (g2_q | st2_q);
      RM_RMM:  inc = g2_q;
      RM_RNE:  inc = g2_q & (st2_q | sig2_q[0]);
      default: inc = g2_q & (st2_q | sig2_q[0]);
    endcase
  end

  assign sum   = {1'b0, sig2_q} + (SW+1)'(inc);
  assign exp3  = 8'(msb2_q) + 8'(BIAS) + {7'd0, sum[SW]};
  assign frac3 = sum[SW] ? sum[SW-1:1] : sum[MANT_W-1:0];

  always_comb begin
    res3_d            = zero2_q ? 32'h0000_0000 : {sign2_q, exp3, frac3};
    flags3_d          = '0;
    flags3_d[FLAG_NV] = 1'b0;
    flags3_d[FLAG_DZ] = 1'b0;
    flags3_d[FLAG_OF] = 1'b0;
    flags3_d[FLAG_UF] = 1'b0;
    flags3_d[FLAG_NX] = ~zero2_q & (g2_q | st2_q);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      res_q   <= '0;
      flags_q <= '0;
      tag3_q  <= '0;
    end else if (adv3 && v2_q) begin
      res_q   <= res3_d;
      flags_q <= flags3_d;
      tag3_q  <= tag2_q;
    end
  end

  assign out_valid_o = v3_q;
  assign result_o    = res_q;
  assign fflags_o    = flags_q;
  assign tag_o       = tag3_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_cvt_to_float_pipe.sv
// Directed bench: vector table on 32- and 64-bit instances, then back-pressure,
// flush and mid-stream reset sequences on the 32-bit instance.
`default_nettype none

module tb_fpu_cvt_to_float_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, iv32, iv64, uns, ordy;
  logic [2:0]  rm;
  logic [4:0]  tag;
  logic [31:0] a32;
  logic [63:0] a64;
  logic        ir32, ov32, ir64, ov64;
  logic [31:0] r32, r64;
  logic [4:0]  f32, f64, t32, t64;

  int checks = 0;
  int errors = 0;

  fpu_cvt_to_float_pipe #(.IN_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .in_valid_i(iv32), .in_ready_o(ir32),
    .a_i(a32), .is_unsigned_i(uns), .rm_i(rm), .tag_i(tag), .out_valid_o(ov32),
    .out_ready_i(ordy), .result_o(r32), .fflags_o(f32), .tag_o(t32)
  );

  fpu_cvt_to_float_pipe #(.IN_WIDTH(64), .TAG_WIDTH(5)) dut64 (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .in_valid_i(iv64), .in_ready_o(ir64),
    .a_i(a64), .is_unsigned_i(uns), .rm_i(rm), .tag_i(tag), .out_valid_o(ov64),
    .out_ready_i(ordy), .result_o(r64), .fflags_o(f64), .tag_o(t64)
  );

  typedef struct {
    logic        w64;
    logic [63:0] a;
    logic        uns;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        nx;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  logic [31:0] bp_exp [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic        ov;
    logic [31:0] r;
    logic [4:0]  f, t;
    uns = v.uns; rm = v.rm; tag = 5'(idx);
    if (v.w64) begin a64 = v.a; iv64 = 1'b1; end
    else begin a32 = v.a[31:0]; iv32 = 1'b1; end
    @(posedge clk); #1; iv32 = 1'b0; iv64 = 1'b0;
    @(posedge clk); #1;
    ov = v.w64 ? ov64 : ov32;
    chk($sformatf("vec%0d_valid_early", idx), 64'(ov), 64'd0);
    @(posedge clk); #1;
    ov = v.w64 ? ov64 : ov32;
    r  = v.w64 ? r64 : r32;
    f  = v.w64 ? f64 : f32;
    t  = v.w64 ? t64 : t32;
    chk($sformatf("vec%0d_valid", idx), 64'(ov), 64'd1);
    chk($sformatf("vec%0d_result", idx), 64'(r), 64'(v.res));
    chk($sformatf("vec%0d_fflags", idx), 64'(f), 64'({4'b0000, v.nx}));
    chk($sformatf("vec%0d_tag", idx), 64'(t), 64'(idx));
  endtask

  task automatic backpressure();
    int          got;
    logic        have_held;
    logic [31:0] held_r;
    logic [4:0]  held_t;
    ordy = 1'b0; uns = 1'b0; rm = 3'b000;
    fork
      begin
        int  waitc;
        logic acc;
        for (int k = 0; k < 6; k++) begin
          waitc = 0; acc = 1'b0;
          a32 = 32'(k + 1); tag = 5'(k); iv32 = 1'b1;
          while (!acc && waitc < 50) begin
            @(negedge clk); acc = ir32;
            @(posedge clk); #1; waitc++;
          end
          if (!acc) chk($sformatf("bp_accept_timeout%0d", k), 64'd0, 64'd1);
        end
        iv32 = 1'b0;
      end
      begin
        got = 0; have_held = 1'b0; held_r = '0; held_t = '0;
        for (int c = 0; c < 60 && got < 6; c++) begin
          @(negedge clk);
          if (c == 5) chk("bp_in_ready_full", 64'(ir32), 64'd0);
          if (ov32 && !ordy) begin
            if (have_held) begin
              chk("bp_stall_result", 64'(r32), 64'(held_r));
              chk("bp_stall_tag", 64'(t32), 64'(held_t));
            end else begin
              held_r = r32; held_t = t32; have_held = 1'b1;
            end
          end
          if (ov32 && ordy) begin
            chk($sformatf("bp_tag%0d", got), 64'(t32), 64'(got));
            chk($sformatf("bp_result%0d", got), 64'(r32), 64'(bp_exp[got]));
            got++;
          end
          @(posedge clk); #1;
          ordy = (c >= 6);
        end
        chk("bp_count", 64'(got), 64'd6);
      end
    join
    ordy = 1'b1;
  endtask

  task automatic flush_seq();
    int seen;
    ordy = 1'b0; uns = 1'b0; rm = 3'b000;
    for (int k = 0; k < 3; k++) begin
      a32 = 32'(k + 1); tag = 5'(k); iv32 = 1'b1;
      @(negedge clk);
      chk($sformatf("fl_ready%0d", k), 64'(ir32), 64'd1);
      @(posedge clk); #1;
    end
    flush = 1'b1; ordy = 1'b1; a32 = 32'd9; tag = 5'd9; iv32 = 1'b1;
    @(negedge clk);
    chk("fl_valid_before", 64'(ov32), 64'd1);
    chk("fl_in_ready_preflush", 64'(ir32), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; iv32 = 1'b0;
    chk("fl_valid_after", 64'(ov32), 64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    chk("fl_no_leftover", 64'(seen), 64'd0);
  endtask

  task automatic reset_seq();
    int seen;
    ordy = 1'b1; uns = 1'b0; rm = 3'b000;
    iv32 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a32 = 32'(k + 5); tag = 5'(k + 3);
      @(posedge clk); #1;
    end
    chk("rs_valid_before", 64'(ov32), 64'd1);
    chk("rs_result_before", 64'(r32), 64'h40A0_0000);
    #2; rst_n = 1'b0; iv32 = 1'b0;
    #1;
    chk("rs_valid_async", 64'(ov32), 64'd0);
    chk("rs_result_async", 64'(r32), 64'd0);
    chk("rs_tag_async", 64'(t32), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    chk("rs_no_partial", 64'(seen), 64'd0);
    chk("rs_in_ready", 64'(ir32), 64'd1);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 64'h0000_0001, 1'b0, 3'b000, 32'h3F80_0000, 1'b0};
    vecs[1]  = '{1'b0, 64'hFFFF_FFFF, 1'b0, 3'b000, 32'hBF80_0000, 1'b0};
    vecs[2]  = '{1'b0, 64'hFFFF_FFFF, 1'b1, 3'b000, 32'h4F80_0000, 1'b1};
    vecs[3]  = '{1'b0, 64'hFFFF_FFFF, 1'b1, 3'b001, 32'h4F7F_FFFF, 1'b1};
    vecs[4]  = '{1'b0, 64'h8000_0000, 1'b0, 3'b000, 32'hCF00_0000, 1'b0};
    vecs[5]  = '{1'b0, 64'h0000_0000, 1'b0, 3'b010, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 64'h0100_0001, 1'b1, 3'b000, 32'h4B80_0000, 1'b1};
    vecs[7]  = '{1'b0, 64'h0100_0001, 1'b1, 3'b011, 32'h4B80_0001, 1'b1};
    vecs[8]  = '{1'b0, 64'h0100_0001, 1'b1, 3'b100, 32'h4B80_0001, 1'b1};
    vecs[9]  = '{1'b0, 64'h0100_0003, 1'b1, 3'b000, 32'h4B80_0002, 1'b1};
    vecs[10] = '{1'b0, 64'h0100_0003, 1'b1, 3'b101, 32'h4B80_0002, 1'b1};
    vecs[11] = '{1'b0, 64'hFEFF_FFFF, 1'b0, 3'b010, 32'hCB80_0001, 1'b1};
    vecs[12] = '{1'b0, 64'hFEFF_FFFF, 1'b0, 3'b011, 32'hCB80_0000, 1'b1};
    vecs[13] = '{1'b0, 64'h00FF_FFFF, 1'b1, 3'b000, 32'h4B7F_FFFF, 1'b0};
    vecs[14] = '{1'b0, 64'h0000_0007, 1'b0, 3'b001, 32'h40E0_0000, 1'b0};
    vecs[15] = '{1'b0, 64'hFFFF_FFFF, 1'b1, 3'b010, 32'h4F7F_FFFF, 1'b1};
    vecs[16] = '{1'b0, 64'h0000_0000, 1'b1, 3'b011, 32'h0000_0000, 1'b0};
    vecs[17] = '{1'b1, 64'h8000_0000_0000_0000, 1'b0, 3'b000, 32'hDF00_0000, 1'b0};
    vecs[18] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'b000, 32'h5F80_0000, 1'b1};
    vecs[19] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'b000, 32'hBF80_0000, 1'b0};
    bp_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
               32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

    rst_n = 1'b0; flush = 1'b0; iv32 = 1'b0; iv64 = 1'b0; uns = 1'b0;
    ordy = 1'b1; rm = 3'b000; tag = '0; a32 = '0; a64 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(ov32), 64'd0);
    chk("reset_result", 64'(r32), 64'd0);
    chk("reset_fflags", 64'(f32), 64'd0);
    chk("reset_tag", 64'(t32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready32", 64'(ir32), 64'd1);
    chk("reset_in_ready64", 64'(ir64), 64'd1);
    chk("reset_valid_after", 64'(ov32), 64'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    @(posedge clk); #1;
    backpressure();
    repeat (3) @(posedge clk);
    #1;
    flush_seq();
    @(posedge clk); #1;
    reset_seq();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
